// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the 16-to-8 narrowing FIFO.
package fifo_pkg;

  localparam int unsigned DEPTH_DEFAULT = 256;

  // wr_data[7:0] leaves the FIFO before wr_data[15:8].
  localparam bit LOW_BYTE_FIRST = 1'b1;

  // Byte address width for a FIFO of the given byte depth.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter width; one extra bit so a full FIFO is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_2x8.sv
// Simple dual-port byte RAM: 16-bit write at an even byte address, 8-bit registered read.
// Two 8-bit banks selected by byte-address bit 0 keep it block-RAM inferable.
module fifo_ram_2x8
  import fifo_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-2:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int unsigned WORDS = 2 ** (AW - 1);

  logic [7:0] bank0 [WORDS];
  logic [7:0] bank1 [WORDS];

  // Word write: even byte goes to bank0, odd byte to bank1.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank0[wr_addr] <= LOW_BYTE_FIRST ? wr_data[7:0]  : wr_data[15:8];
      bank1[wr_addr] <= LOW_BYTE_FIRST ? wr_data[15:8] : wr_data[7:0];
    end
  end

  // Registered byte read; output holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= rd_addr[0] ? bank1[rd_addr[AW-1:1]] : bank0[rd_addr[AW-1:1]];
    end
  end

endmodule

// File: rtl/fifo_16to8.sv
// Single-clock FIFO: 16-bit words in, bytes out low byte first, one-cycle read latency.
module fifo_16to8
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned AW = addr_w(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          wr_req,
  input  logic [15:0]   wr_data,
  output logic          wr_full,
  output logic          wr_empty,
  output logic [AW-1:0] wr_usedw,
  input  logic          rd_req,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          rd_empty,
  output logic          rd_full,
  output logic [AW:0]   rd_usedw
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_HIWAT = CW'(DEPTH - 2);

  logic [CW-1:0] count;
  // Write pointer kept as a word index; the byte pointer {wr_wptr, 1'b0} is always even.
  logic [AW-2:0] wr_wptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;

  // Flags and usedw come straight from the post-edge count; no look-ahead on requests.
  assign wr_full  = (count > CNT_HIWAT);
  assign rd_full  = (count == CNT_DEPTH);
  assign wr_empty = (count == '0);
  assign rd_empty = (count == '0);
  assign wr_usedw = count[CW-1:1];
  assign rd_usedw = count;

  // Accept decisions use pre-edge flags, so a write into an empty FIFO cannot be read through.
  assign wr_acc = wr_req && !wr_full && !sys_rst;
  assign rd_acc = rd_req && !rd_empty && !sys_rst;

  fifo_ram_2x8 #(
    .AW (AW)
  ) u_ram (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_wptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers, byte counter and read-valid strobe.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count    <= '0;
      wr_wptr  <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_wptr <= wr_wptr + 1'b1;
      if (rd_acc) rd_ptr  <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(2);
        2'b01:   count <= count - CW'(1);
        2'b11:   count <= count + CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_16to8.sv
// Directed self-checking bench for fifo_16to8 (DEPTH = 256).
module tb_fifo_16to8;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        wr_full;
  logic        wr_empty;
  logic [7:0]  wr_usedw;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_empty;
  logic        rd_full;
  logic [8:0]  rd_usedw;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference byte queue; its size is the expected occupancy.
  logic [7:0] sb[$];
  logic [7:0] last_rd;

  always #5 sys_clk = ~sys_clk;

  fifo_16to8 dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .wr_full  (wr_full),
    .wr_empty (wr_empty),
    .wr_usedw (wr_usedw),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_empty (rd_empty),
    .rd_full  (rd_full),
    .rd_usedw (rd_usedw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " wr_full"},  32'(wr_full),  0);
    chk({tag, " wr_empty"}, 32'(wr_empty), 1);
    chk({tag, " wr_usedw"}, 32'(wr_usedw), 0);
    chk({tag, " rd_empty"}, 32'(rd_empty), 1);
    chk({tag, " rd_full"},  32'(rd_full),  0);
    chk({tag, " rd_usedw"}, 32'(rd_usedw), 0);
    chk({tag, " rd_data"},  32'(rd_data),  0);
    chk({tag, " rd_valid"}, 32'(rd_valid), 0);
  endtask

  // One clock with the given requests; the model decides acceptance from pre-edge occupancy.
  task automatic cyc(input logic wr, input logic [15:0] d, input logic rd, input string tag);
    int  pre;
    logic wa, ra;
    logic [7:0] exp_b;
    pre = sb.size();
    wa = wr && (pre <= 254);
    ra = rd && (pre != 0);
    exp_b = last_rd;
    if (ra) exp_b = sb.pop_front();
    if (wa) begin
      sb.push_back(d[7:0]);
      sb.push_back(d[15:8]);
    end
    wr_req = wr; wr_data = d; rd_req = rd;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(ra));
    chk({tag, " rd_data"},  32'(rd_data),  32'(exp_b));
    chk({tag, " rd_usedw"}, 32'(rd_usedw), 32'(sb.size()));
    chk({tag, " wr_full"},  32'(wr_full),  32'(sb.size() > 254));
    last_rd = exp_b;
  endtask

  initial begin
    sys_rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = 16'h0000;
    last_rd = 8'h00;
    tick();
    sys_rst = 1'b0;
    chk_reset_state("reset");

    // Fill with bytes 00..FF, no reads.
    for (int i = 0; i < 128; i++) begin
      wr_req = 1'b1;
      wr_data = {8'(2 * i + 1), 8'(2 * i)};
      tick();
      if (i == 0) begin
        chk("first write rd_empty", 32'(rd_empty), 0);
        chk("first write rd_usedw", 32'(rd_usedw), 2);
      end
    end
    wr_req = 1'b0;
    chk("fill wr_full",  32'(wr_full),  1);
    chk("fill rd_full",  32'(rd_full),  1);
    chk("fill rd_usedw", 32'(rd_usedw), 256);
    chk("fill wr_usedw", 32'(wr_usedw), 128);

    wr_req = 1'b1; wr_data = 16'hFFFF;
    tick();
    wr_req = 1'b0;
    chk("drop write rd_usedw", 32'(rd_usedw), 256);

    // Drain with rd_req held for 257 cycles.
    rd_req = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      chk("drain rd_valid", 32'(rd_valid), 1);
      chk("drain rd_data",  32'(rd_data),  32'(k));
      chk("drain rd_usedw", 32'(rd_usedw), 32'(255 - k));
    end
    tick();
    rd_req = 1'b0;
    chk("drain end rd_empty", 32'(rd_empty), 1);
    chk("drain end rd_valid", 32'(rd_valid), 0);
    chk("drain end rd_data",  32'(rd_data),  32'h00FF);

    // Byte order and odd count.
    wr_req = 1'b1; wr_data = 16'hBEEF;
    tick();
    wr_req = 1'b0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("beef rd_data",  32'(rd_data),  32'h00EF);
    chk("beef rd_valid", 32'(rd_valid), 1);
    chk("beef rd_usedw", 32'(rd_usedw), 1);
    chk("beef wr_usedw", 32'(wr_usedw), 0);
    chk("beef wr_empty", 32'(wr_empty), 0);
    chk("beef wr_full",  32'(wr_full),  0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("beef 2nd rd_data", 32'(rd_data), 32'h00BE);
    tick();
    chk("beef idle rd_valid", 32'(rd_valid), 0);
    chk("beef idle rd_data",  32'(rd_data),  32'h00BE);
    last_rd = 8'hBE;

    // Move pointers next to the wrap: byte ptrs now at 2.
    for (int i = 0; i < 127; i++) cyc(1'b1, 16'(32'hA000 + i * 32'h0103), 1'b0, "pre wr");
    for (int i = 0; i < 252; i++) cyc(1'b0, 16'h0000, 1'b1, "pre rd");
    cyc(1'b1, 16'h5A4B, 1'b0, "pre wr2");
    cyc(1'b1, 16'h7C6D, 1'b0, "pre wr3");
    cyc(1'b0, 16'h0000, 1'b1, "pre rd2");
    chk("sim start count", 32'(rd_usedw), 5);

    // Simultaneous read and write across the pointer wrap.
    cyc(1'b1, 16'h1122, 1'b1, "sim0");
    chk("sim count 6", 32'(rd_usedw), 6);
    cyc(1'b1, 16'h3344, 1'b1, "sim1");
    chk("sim count 7", 32'(rd_usedw), 7);
    cyc(1'b1, 16'h5566, 1'b1, "sim2");
    chk("sim count 8", 32'(rd_usedw), 8);

    // Near-full edge at count 255.
    for (int i = 0; i < 124; i++) cyc(1'b1, 16'(32'hC000 + i * 32'h0305), 1'b0, "nf wr");
    cyc(1'b0, 16'h0000, 1'b1, "nf rd");
    chk("nf count 255", 32'(rd_usedw), 255);
    chk("nf wr_full",   32'(wr_full),  1);
    chk("nf rd_full",   32'(rd_full),  0);
    chk("nf wr_usedw",  32'(wr_usedw), 127);
    cyc(1'b1, 16'hDEAD, 1'b0, "nf drop");
    chk("nf drop count", 32'(rd_usedw), 255);
    cyc(1'b0, 16'h0000, 1'b1, "nf rd254");
    chk("nf count 254", 32'(rd_usedw), 254);
    chk("nf 254 wr_full", 32'(wr_full), 0);
    cyc(1'b1, 16'hCAFE, 1'b0, "nf wr256");
    chk("nf count 256", 32'(rd_usedw), 256);
    chk("nf 256 rd_full", 32'(rd_full), 1);

    // Reset mid-stream at count 37.
    for (int i = 0; i < 219; i++) cyc(1'b0, 16'h0000, 1'b1, "rs rd");
    chk("rs count 37", 32'(rd_usedw), 37);
    sys_rst = 1'b1; wr_req = 1'b1; wr_data = 16'h9999; rd_req = 1'b1;
    tick();
    sys_rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    chk_reset_state("mid reset");
    sb.delete();
    last_rd = 8'h00;
    cyc(1'b1, 16'h1234, 1'b0, "post rst wr");
    cyc(1'b0, 16'h0000, 1'b1, "post rst rd0");
    chk("post rst byte0", 32'(rd_data), 32'h0034);
    cyc(1'b0, 16'h0000, 1'b1, "post rst rd1");
    chk("post rst byte1", 32'(rd_data), 32'h0012);
    chk("post rst empty", 32'(rd_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_16to8.md
# fifo_16to8

Single-clock, mixed-width synchronous FIFO: 16-bit words in, 8-bit bytes out, low byte first. It is the narrowing counterpart to the team's 8-to-16 dual-clock FIFO. It sits between a 16-bit producer (packer, DMA word stream) and a byte-serial consumer (UART TX, byte-wide display bus) in the same clock domain. Reads use normal (non-show-ahead) mode with one-cycle read latency.

## Interface
Parameters:
- DEPTH — 256 — capacity in bytes; power of two, ≥ 4.
- AW — $clog2(DEPTH) — byte address width (derived, not overridden).

Ports:
- sys_clk  in  1  — single clock; all logic on rising edge.
- sys_rst  in  1  — reset, synchronous, active-high.
- wr_req  in  1  — write one 16-bit word this cycle.
- wr_data  in  16  — write word; [7:0] is read out first, [15:8] second.
- wr_full  out  1  — fewer than 2 free bytes; writes are ignored.
- wr_empty  out  1  — byte count == 0.
- wr_usedw  out  AW  — whole words stored = count >> 1.
- rd_req  in  1  — read one byte this cycle.
- rd_data  out  8  — byte returned one cycle after an accepted read; holds otherwise.
- rd_valid  out  1  — high for exactly one cycle when rd_data is updated.
- rd_empty  out  1  — byte count == 0; reads are ignored.
- rd_full  out  1  — byte count == DEPTH.
- rd_usedw  out  AW+1  — bytes stored, 0..DEPTH.

## Operation
- State:
  - byte counter `count` (AW+1 bits, 0..DEPTH);
  - wr_ptr (AW bits, always even, steps by 2);
  - rd_ptr (AW bits, steps by 1);
  - storage of DEPTH bytes.
- Write accepted: wr_req && !wr_full. Stores wr_data[7:0] at wr_ptr and wr_data[15:8] at wr_ptr+1, then wr_ptr += 2.
- Read accepted: rd_req && !rd_empty. Byte at rd_ptr is registered into rd_data, rd_valid = 1 next cycle, rd_ptr += 1.
- Count update: +2 for an accepted write, −1 for an accepted read, +1 for both in the same cycle.
- Flags are combinational from count:
  - wr_full = (count > DEPTH−2);
  - rd_full = (count == DEPTH);
  - rd_empty = wr_empty = (count == 0).
- Pointer wrap: modulo DEPTH, natural AW-bit rollover. wr_ptr never becomes odd.
- Odd occupancy is legal:
  - count may be odd (consumer mid-word); wr_usedw floors.
  - count == DEPTH−1 → wr_full = 1, rd_full = 0.
- Write when wr_full: dropped, no state change, no error flag.
- Read when rd_empty: dropped; rd_data holds, rd_valid = 0.
- Write into an empty FIFO with a simultaneous read: the read is rejected, because rd_empty is evaluated from the pre-edge count. No write-through bypass.
- Read and write to the same storage location in one cycle cannot occur: occupancy guarantees distinct addresses.

## Timing
- Reset (sys_rst sampled high at an edge) clears:
  - count = 0, wr_ptr = 0, rd_ptr = 0;
  - rd_data = 8'h00, rd_valid = 0.
- Resulting output values:
  - wr_full = 0, wr_empty = 1, wr_usedw = 0;
  - rd_empty = 1, rd_full = 0, rd_usedw = 0.
- Storage contents are not reset.
- Reset mid-operation discards all contents. It has priority over wr_req and rd_req in the same cycle.
- Write-to-flag latency: 1 cycle. rd_empty deasserts and rd_usedw = 2 on the edge after the write edge.
- Read latency: rd_req accepted at edge N → rd_data/rd_valid valid after edge N+1.
- Back-to-back reads every cycle are sustained. Back-to-back writes every cycle are sustained until wr_full.
- Flags and usedw reflect count after the last edge; they do not look ahead at current requests.

## Structure
- Shared package fifo_pkg holds:
  - default DEPTH;
  - derived width helpers for AW and AW+1;
  - the byte-order constant (LOW_BYTE_FIRST = 1).
- One sub-module: fifo_ram_2x8, a simple dual-port byte RAM.
  - Write side: 2-byte write at an even address.
  - Read side: 1-byte registered read.
  - Inferable as block RAM (two 8-bit banks indexed by address bit 0).
- Top level holds pointers, counter, flags and the rd_valid register.

## Test plan
- Reset then fill: write 16'h0100, 16'h0302 … for DEPTH/2 words with no reads.
  - After the last write: wr_full = 1, rd_full = 1, rd_usedw = 256, wr_usedw = 128.
  - An extra write of 16'hFFFF is dropped and count stays 256.
- Drain: with the FIFO full, hold rd_req for 257 cycles.
  - rd_data sequence is 00, 01, 02 … FF with rd_valid per byte.
  - Then rd_empty = 1, rd_valid = 0, rd_data holds FF.
- Byte order and odd count: write 16'hBEEF, read once.
  - rd_data = EF; rd_usedw = 1, wr_usedw = 0, wr_empty = 0.
  - Read again: rd_data = BE.
- Simultaneous access: from count = 5, assert wr_req and rd_req together for 3 cycles.
  - Count goes 6, 7, 8.
  - Bytes read out are in exact write order across the pointer wrap, checked by a scoreboard.
- Near-full edge: bring count to 255.
  - wr_full = 1, rd_full = 0, a write is dropped.
  - One read gives count 254 and wr_full = 0; the next write gives count 256.
- Reset mid-stream: at count = 37 assert sys_rst together with wr_req and rd_req.
  - Next cycle: all outputs are at reset values and rd_valid = 0.
  - A subsequent write of 16'h1234 reads back 34 then 12.
